systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl_if.sv | 68 ++++++
 rtl/systolic_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_ctrl_if
//  Description : Control/status bundle between a host and the systolic-array
//                tile sequencer. The master issues start/abort and observes
//                status and datapath enables; the slave is the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface systolic_ctrl_if #(
    parameter int ARRAYHEIGHT = 4
);
    localparam int ADDR_W = $clog2(2 * ARRAYHEIGHT);
    localparam int IDX_W  = $clog2(ARRAYHEIGHT) + 1;

    // Host requests
    logic              start;
    logic              abort;

    // Sequencer status
    logic              busy;
    logic              done;

    // Datapath enables
    logic              weight_buffer_load_en;
    logic              write_weight_en;
    logic              weight_buffer_out_en;
    logic              input_buffer_load_en;
    logic              input_buffer_out_en;
    logic              output_buffer_load_en;
    logic              output_buffer_out_en;

    // Addressing
    logic [ADDR_W-1:0] rd_addr;
    logic [IDX_W-1:0]  res_idx;

    modport master (
        output start,
        output abort,
        input  busy,
        input  done,
        input  weight_buffer_load_en,
        input  write_weight_en,
        input  weight_buffer_out_en,
        input  input_buffer_load_en,
        input  input_buffer_out_en,
        input  output_buffer_load_en,
        input  output_buffer_out_en,
        input  rd_addr,
        input  res_idx
    );

    modport slave (
        input  start,
        input  abort,
        output busy,
        output done,
        output weight_buffer_load_en,
        output write_weight_en,
        output weight_buffer_out_en,
        output input_buffer_load_en,
        output input_buffer_out_en,
        output output_buffer_load_en,
        output output_buffer_out_en,
        output rd_addr,
        output res_idx
    );
endinterface
`default_nettype wire

// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_ctrl
//  Description : Tile sequencer for a weight-stationary systolic array.
//                Walks LOAD_W -> FEED -> SKEW -> ACC -> UNLOAD -> DONE with a
//                single reloadable down-counter timing every phase, and
//                decodes all datapath enables from the registered state.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_ctrl #(
    parameter int ARRAYHEIGHT = 4,
    parameter int ARRAYWIDTH  = 4,
    parameter int DSP_DELAY   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    systolic_ctrl_if.slave ctrl
);

    // ------------------------------------------------------------------
    // Phase lengths and derived widths
    // ------------------------------------------------------------------
    localparam int ADDR_W     = $clog2(2 * ARRAYHEIGHT);
    localparam int IDX_W      = $clog2(ARRAYHEIGHT) + 1;

    localparam int LOAD_LEN   = ARRAYHEIGHT;
    localparam int FEED_LEN   = ARRAYHEIGHT;
    localparam int SKEW_LEN   = DSP_DELAY * (ARRAYWIDTH - 1);
    localparam int ACC_LEN    = 2 * DSP_DELAY * ARRAYHEIGHT;
    localparam int UNLOAD_LEN = ARRAYHEIGHT;

    // The counter must hold the longest phase; SKEW can exceed ACC for
    // very wide, shallow arrays, so size for whichever is larger.
    localparam int MAX_A      = (ACC_LEN > SKEW_LEN) ? ACC_LEN : SKEW_LEN;
    localparam int MAX_LEN    = (MAX_A > LOAD_LEN) ? MAX_A : LOAD_LEN;
    localparam int CNT_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN + 1) : 1;

    // A zero-length skew (single column or zero-latency PEs) is bypassed.
    localparam bit SKIP_SKEW  = (SKEW_LEN == 0);

    // Counter reload values: the counter runs from LEN-1 down to 0, so the
    // phase ends in the cycle where it reads zero.
    localparam logic [CNT_W-1:0] LOAD_RL   = CNT_W'(LOAD_LEN - 1);
    localparam logic [CNT_W-1:0] FEED_RL   = CNT_W'(FEED_LEN - 1);
    localparam logic [CNT_W-1:0] SKEW_RL   = CNT_W'(SKEW_LEN - 1);
    localparam logic [CNT_W-1:0] ACC_RL    = CNT_W'(ACC_LEN - 1);
    localparam logic [CNT_W-1:0] UNLOAD_RL = CNT_W'(UNLOAD_LEN - 1);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        FEED   = 3'd2,
        SKEW   = 3'd3,
        ACC    = 3'd4,
        UNLOAD = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] w_rd_addr_next;
    logic [IDX_W-1:0]  r_res_idx;
    logic [IDX_W-1:0]  w_res_idx_next;
    logic              w_last;

    assign w_last = (r_cnt == '0);

    // State, phase counter and address registers; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rd_addr <= '0;
            r_res_idx <= '0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_next;
            r_rd_addr <= w_rd_addr_next;
            r_res_idx <= w_res_idx_next;
        end
    end

    // Next-state logic: phases advance when the counter reaches zero; abort
    // overrides everything and returns straight to IDLE, skipping DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (ctrl.start) begin
                    w_next_state = LOAD_W;
                end
            end
            LOAD_W: begin
                if (w_last) begin
                    w_next_state = FEED;
                end
            end
            FEED: begin
                if (w_last) begin
                    w_next_state = SKIP_SKEW ? ACC : SKEW;
                end
            end
            SKEW: begin
                if (w_last) begin
                    w_next_state = ACC;
                end
            end
            ACC: begin
                if (w_last) begin
                    w_next_state = UNLOAD;
                end
            end
            UNLOAD: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (ctrl.abort) begin
            w_next_state = IDLE;
        end
    end

    // Counter reloads on every state change and otherwise counts down,
    // saturating at zero so it can never wrap.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next_state != r_state) begin
            case (w_next_state)
                LOAD_W:  w_cnt_next = LOAD_RL;
                FEED:    w_cnt_next = FEED_RL;
                SKEW:    w_cnt_next = SKEW_RL;
                ACC:     w_cnt_next = ACC_RL;
                UNLOAD:  w_cnt_next = UNLOAD_RL;
                default: w_cnt_next = '0;
            endcase
        end else if (!w_last) begin
            w_cnt_next = r_cnt - CNT_W'(1);
        end
    end

    // Row address walks 0..H-1 through LOAD_W and continues H..2H-1 through
    // FEED; any other destination (including abort) zeroes it.
    always_comb begin
        w_rd_addr_next = '0;
        case (w_next_state)
            LOAD_W: begin
                if (r_state == LOAD_W) begin
                    w_rd_addr_next = r_rd_addr + ADDR_W'(1);
                end
            end
            FEED: begin
                w_rd_addr_next = r_rd_addr + ADDR_W'(1);
            end
            default: begin
                w_rd_addr_next = '0;
            end
        endcase
    end

    // Result index starts at 0 on UNLOAD entry, steps each UNLOAD cycle and
    // lands on ARRAYHEIGHT for the DONE cycle; cleared everywhere else.
    always_comb begin
        w_res_idx_next = '0;
        case (w_next_state)
            UNLOAD: begin
                if (r_state == UNLOAD) begin
                    w_res_idx_next = r_res_idx + IDX_W'(1);
                end
            end
            DONE: begin
                w_res_idx_next = r_res_idx + IDX_W'(1);
            end
            default: begin
                w_res_idx_next = '0;
            end
        endcase
    end

    // Outputs are pure decodes of registered state and registers.
    assign ctrl.busy                  = (r_state != IDLE);
    assign ctrl.done                  = (r_state == DONE);
    assign ctrl.weight_buffer_load_en = (r_state == LOAD_W);
    assign ctrl.write_weight_en       = (r_state == FEED);
    assign ctrl.weight_buffer_out_en  = (r_state == FEED);
    assign ctrl.input_buffer_load_en  = (r_state == FEED);
    assign ctrl.input_buffer_out_en   = (r_state == SKEW) || (r_state == ACC);
    assign ctrl.output_buffer_load_en = (r_state == ACC);
    assign ctrl.output_buffer_out_en  = (r_state == UNLOAD);
    assign ctrl.rd_addr               = r_rd_addr;
    assign ctrl.res_idx               = r_res_idx;

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_ctrl
//  Description : Directed self-checking bench for systolic_ctrl. Cycle 0 is
//                the first LOAD_W cycle; expected output vectors per cycle
//                come from hand-written phase tables.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    systolic_ctrl_if #(.ARRAYHEIGHT(4)) bus  ();
    systolic_ctrl_if #(.ARRAYHEIGHT(4)) bus1 ();

    systolic_ctrl #(
        .ARRAYHEIGHT (4),
        .ARRAYWIDTH  (4),
        .DSP_DELAY   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    systolic_ctrl #(
        .ARRAYHEIGHT (4),
        .ARRAYWIDTH  (1),
        .DSP_DELAY   (2)
    ) dut_w1 (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus1)
    );

    // Observed vector: {busy, done, wle, wwe, wbo, ile, ibo, ole, obo, rd_addr, res_idx}
    function automatic logic [14:0] obs_main();
        return {bus.busy, bus.done, bus.weight_buffer_load_en, bus.write_weight_en,
                bus.weight_buffer_out_en, bus.input_buffer_load_en, bus.input_buffer_out_en,
                bus.output_buffer_load_en, bus.output_buffer_out_en, bus.rd_addr, bus.res_idx};
    endfunction

    function automatic logic [14:0] obs_w1();
        return {bus1.busy, bus1.done, bus1.weight_buffer_load_en, bus1.write_weight_en,
                bus1.weight_buffer_out_en, bus1.input_buffer_load_en, bus1.input_buffer_out_en,
                bus1.output_buffer_load_en, bus1.output_buffer_out_en, bus1.rd_addr, bus1.res_idx};
    endfunction

    // H=4 W=4 D=2: LOAD_W 0-3, FEED 4-7, SKEW 8-13, ACC 14-29, UNLOAD 30-33, DONE 34
    function automatic logic [14:0] exp4(input int c);
        logic feed, obo, dn;
        int   rd, ri;
        if (c < 0 || c > 34) return '0;
        feed = (c >= 4 && c <= 7);
        obo  = (c >= 30 && c <= 33);
        dn   = (c == 34);
        rd   = (c <= 7) ? c : 0;
        ri   = obo ? (c - 30) : (dn ? 4 : 0);
        return {1'b1, dn, (c <= 3), feed, feed, feed, (c >= 8 && c <= 29),
                (c >= 14 && c <= 29), obo, 3'(rd), 3'(ri)};
    endfunction

    // H=4 W=1 D=2: LOAD_W 0-3, FEED 4-7, ACC 8-23, UNLOAD 24-27, DONE 28
    function automatic logic [14:0] exp_w1(input int c);
        logic feed, obo, dn;
        int   rd, ri;
        if (c < 0 || c > 28) return '0;
        feed = (c >= 4 && c <= 7);
        obo  = (c >= 24 && c <= 27);
        dn   = (c == 28);
        rd   = (c <= 7) ? c : 0;
        ri   = obo ? (c - 24) : (dn ? 4 : 0);
        return {1'b1, dn, (c <= 3), feed, feed, feed, (c >= 8 && c <= 23),
                (c >= 8 && c <= 23), obo, 3'(rd), 3'(ri)};
    endfunction

    // Runs one tile on the main instance from #1 after a posedge. Optional
    // extra start pulse, abort, and a second tile offset in the expectation.
    task automatic run_main(input string name, input int start_at, input int abort_at,
                            input int second_off, input int exp_dones, input int last);
        logic [14:0] e;
        logic [14:0] o;
        int          dones = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c <= last; c++) begin
            e = exp4(c);
            if (abort_at >= 0 && c > abort_at) e = '0;
            if (second_off >= 0) e = e | exp4(c - second_off);
            o = obs_main();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, o, e);
            end
            if (o[13]) dones++;
            if (c == start_at) bus.start = 1'b1;
            if (c == abort_at) bus.abort = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
        checks++;
        if (dones !== exp_dones) begin
            errors++;
            $display("FAIL %s_done_count got=%0d expected=%0d", name, dones, exp_dones);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_main() !== 15'h0) begin
            errors++;
            $display("FAIL reset_main got=%h expected=%h", obs_main(), 15'h0);
        end
        checks++;
        if (obs_w1() !== 15'h0) begin
            errors++;
            $display("FAIL reset_w1 got=%h expected=%h", obs_w1(), 15'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_main() !== 15'h0) begin
            errors++;
            $display("FAIL reset_hold got=%h expected=%h", obs_main(), 15'h0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        run_main("single", -1, -1, -1, 1, 36);
    endtask

    task automatic test_start_ignored();
        run_main("start_ignored", 10, -1, -1, 1, 36);
    endtask

    task automatic test_abort();
        run_main("abort", -1, 20, -1, 0, 24);
        run_main("after_abort", -1, -1, -1, 1, 36);
    endtask

    task automatic test_abort_start_idle();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_main() !== 15'h0) begin
                errors++;
                $display("FAIL abort_wins_idle step=%0d got=%h expected=%h", i, obs_main(), 15'h0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] o;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            o = obs_main();
            checks++;
            if (o !== exp4(c)) begin
                errors++;
                $display("FAIL reset_mid_pre cycle=%0d got=%h expected=%h", c, o, exp4(c));
            end
            if (c < 16) begin
                @(posedge clk); #1;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_main() !== 15'h0) begin
            errors++;
            $display("FAIL reset_mid_async got=%h expected=%h", obs_main(), 15'h0);
        end
        @(posedge clk); #1;
        checks++;
        if (obs_main() !== 15'h0) begin
            errors++;
            $display("FAIL reset_mid_held got=%h expected=%h", obs_main(), 15'h0);
        end
        rst_n = 1'b1;
        run_main("after_reset", -1, -1, -1, 1, 36);
    endtask

    task automatic test_no_skew();
        logic [14:0] o;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        for (int c = 0; c <= 30; c++) begin
            o = obs_w1();
            checks++;
            if (o !== exp_w1(c)) begin
                errors++;
                $display("FAIL no_skew cycle=%0d got=%h expected=%h", c, o, exp_w1(c));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        run_main("back_to_back", 35, -1, 36, 2, 72);
    endtask

    initial begin
        test_reset();
        test_single();
        test_start_ignored();
        test_abort();
        test_abort_start_idle();
        test_reset_mid();
        test_no_skew();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
